// File: rtl/mem_map_pkg.sv
// Memory map shared by the data memory, its timer and core benches.
// Register offsets live inside the 256-byte MMIO window.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] RAM_BASE      = 32'h0000_0000;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_CYC_LO = 8'h04;
  localparam logic [7:0] OFF_CYC_HI = 8'h08;
  localparam logic [7:0] OFF_TCMP   = 8'h0C;
  localparam logic [7:0] OFF_TSTAT  = 8'h10;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CLO,
    SEL_CHI,
    SEL_TCMP,
    SEL_TSTAT
  } sel_e;

  function automatic sel_e mmio_dec(
    input logic [7:0] off
  );
    sel_e s;
    s = SEL_NONE;
    unique case (off)
      OFF_LED:    s = SEL_LED;
      OFF_CYC_LO: s = SEL_CLO;
      OFF_CYC_HI: s = SEL_CHI;
      OFF_TCMP:   s = SEL_TCMP;
      OFF_TSTAT:  s = SEL_TSTAT;
      default:    s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// 64-bit free-running cycle counter with high-word snapshot,
// compare register and sticky match flag.
module cycle_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_lo,
  input  logic        wr_cmp,
  input  logic        wr_stat,
  input  logic [31:0] wd,
  output logic [31:0] cnt_lo,
  output logic [31:0] snap_hi,
  output logic [31:0] cmp,
  output logic        flag
);

  logic [63:0] cnt;
  logic        match;

  assign cnt_lo = cnt[31:0];
  assign match  = (cmp != 32'd0) && (cnt[31:0] == cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 64'd0;
      snap_hi <= 32'd0;
      cmp     <= 32'd0;
      flag    <= 1'b0;
    end else begin
      cnt <= cnt + 64'd1;
      if (ld_lo)
        snap_hi <= cnt[63:32];
      if (wr_cmp)
        cmp <= wd;
      // a match in the same cycle as a clear keeps the flag set
      if (match)
        flag <= 1'b1;
      else if (wr_stat && wd[0])
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Single-cycle data memory: async-read RAM plus LED and timer
// registers in a small MMIO window.
module data_mem_resp
  import mem_map_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  leds,
  output logic        timer_irq,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [7:0]  led_q;
  logic        aligned;
  logic        in_ram;
  logic        in_win;
  logic        wr;
  sel_e        sel;
  logic [31:0] cnt_lo;
  logic [31:0] snap_hi;
  logic [31:0] cmp;
  logic        flag;

  always_comb begin
    aligned = (a[1:0] == 2'b00);
    in_ram  = (a[31:AW+2] == RAM_BASE[31:AW+2]);
    in_win  = (a[31:8] == MMIO_BASE[31:8]);
    sel     = SEL_NONE;
    if (aligned) begin
      unique case (1'b1)
        in_ram:  sel = SEL_RAM;
        in_win:  sel = mmio_dec(a[7:0]);
        default: sel = SEL_NONE;
      endcase
    end
  end

  assign addr_err = (we | re) & (sel == SEL_NONE);
  assign wr       = we & ~reset;

  always_comb begin
    rd = 32'd0;
    unique case (sel)
      SEL_RAM:   rd = mem[a[AW+1:2]];
      SEL_LED:   rd = {24'd0, led_q};
      SEL_CLO:   rd = cnt_lo;
      SEL_CHI:   rd = snap_hi;
      SEL_TCMP:  rd = cmp;
      SEL_TSTAT: rd = {31'd0, flag};
      default:   rd = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr && sel == SEL_RAM)
      mem[a[AW+1:2]] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset)
      led_q <= 8'd0;
    else if (wr && sel == SEL_LED)
      led_q <= wd[7:0];
  end

  cycle_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .ld_lo   (re && sel == SEL_CLO),
    .wr_cmp  (wr && sel == SEL_TCMP),
    .wr_stat (wr && sel == SEL_TSTAT),
    .wd      (wd),
    .cnt_lo  (cnt_lo),
    .snap_hi (snap_hi),
    .cmp     (cmp),
    .flag    (flag)
  );

  assign leds      = led_q;
  assign timer_irq = flag;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp with a scoreboard queue.
// Inputs change at negedge; outputs are sampled 1 ns later.
module tb_data_mem_resp;
  import mem_map_pkg::*;

  localparam logic [31:0] MB = MMIO_BASE_DEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  leds;
  logic        timer_irq;
  logic        addr_err;

  data_mem_resp dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .re        (re),
    .a         (a),
    .wd        (wd),
    .rd        (rd),
    .leds      (leds),
    .timer_irq (timer_irq),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc(input logic w, input logic r,
                     input logic [31:0] ad,
                     input logic [31:0] d);
    @(negedge clk);
    we = w;
    re = r;
    a  = ad;
    wd = d;
    #1;
  endtask

  logic [31:0] v;
  bit          hit;

  initial begin
    reset = 1'b1;
    we = 0; re = 0; a = 0; wd = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    push("rst_leds", 0);       chk({24'd0, leds});
    push("rst_irq", 0);        chk({31'd0, timer_irq});

    @(negedge clk);
    reset = 1'b0;
    re = 1; a = MB + OFF_CYC_LO;
    #1;
    push("cnt_first", 0);      chk(rd);
    cyc(0, 1, MB + OFF_CYC_LO, 0);
    push("cnt_second", 1);     chk(rd);
    cyc(0, 1, MB + OFF_TCMP, 0);
    push("tcmp_rst", 0);       chk(rd);

    cyc(1, 0, MB + OFF_TCMP, 32'd20);
    cyc(0, 1, MB + OFF_TCMP, 0);
    push("tcmp_rb", 20);       chk(rd);

    // RAM read-during-write returns the old word
    cyc(1, 0, 32'h10, 32'h1111_1111);
    cyc(1, 1, 32'h10, 32'hDEAD_BEEF);
    push("ram_old", 32'h1111_1111); chk(rd);
    cyc(0, 1, 32'h10, 0);
    push("ram_new", 32'hDEAD_BEEF); chk(rd);

    cyc(1, 0, MB + OFF_LED, 32'h1A5);
    cyc(0, 1, MB + OFF_LED, 0);
    push("leds", 32'hA5);      chk({24'd0, leds});
    push("led_rd", 32'hA5);    chk(rd);
    cyc(1, 0, MB + OFF_CYC_LO, 32'h1234_5678);
    push("ro_err", 0);         chk({31'd0, addr_err});
    cyc(0, 0, 0, 0);
    push("leds_keep", 32'hA5); chk({24'd0, leds});

    hit = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 1, MB + OFF_CYC_LO, 0);
      if (rd == 32'd20) begin
        hit = 1;
        break;
      end
    end
    push("reach_20", 20);      chk(rd);
    push("irq_pre", 0);        chk({31'd0, timer_irq});
    cyc(0, 0, 0, 0);
    push("irq_set", 1);        chk({31'd0, timer_irq});

    cyc(1, 1, MB + OFF_TSTAT, 1);
    push("stat_rd1", 1);       chk(rd);
    cyc(0, 1, MB + OFF_TSTAT, 0);
    push("stat_rd0", 0);       chk(rd);
    push("irq_clr", 0);        chk({31'd0, timer_irq});

    cyc(0, 1, MB + OFF_CYC_LO, 0);
    v = rd;
    cyc(1, 0, MB + OFF_TCMP, v + 32'd4);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, MB + OFF_TSTAT, 1);
    push("irq_pre2", 0);       chk({31'd0, timer_irq});
    cyc(0, 0, 0, 0);
    push("set_wins", 1);       chk({31'd0, timer_irq});
    cyc(1, 0, MB + OFF_TCMP, 0);
    cyc(0, 0, 0, 0);
    push("cmp_wr_keep", 1);    chk({31'd0, timer_irq});
    cyc(1, 0, MB + OFF_TSTAT, 1);
    cyc(0, 0, 0, 0);
    push("irq_clr2", 0);       chk({31'd0, timer_irq});

    cyc(1, 0, 32'h0, 32'h0BAD_F00D);
    cyc(1, 1, 32'h13, 32'h5555_5555);
    push("mis_err", 1);        chk({31'd0, addr_err});
    push("mis_rd", 0);         chk(rd);
    cyc(1, 1, 32'h8000_0000, 32'h6666_6666);
    push("unm_err", 1);        chk({31'd0, addr_err});
    push("unm_rd", 0);         chk(rd);
    cyc(0, 1, 32'h10, 0);
    push("ram10_keep", 32'hDEAD_BEEF); chk(rd);
    push("ok_err", 0);         chk({31'd0, addr_err});
    cyc(0, 1, 32'h0, 0);
    push("ram0_keep", 32'h0BAD_F00D); chk(rd);
    cyc(0, 1, MB + 32'h14, 0);
    push("hole_err", 1);       chk({31'd0, addr_err});

    // Jump the counter to just below a high-word carry
    @(negedge clk);
    force dut.u_timer.cnt = 64'h0000_0000_FFFF_FFFF;
    we = 0; re = 1; a = MB + OFF_CYC_LO; wd = 0;
    #1;
    release dut.u_timer.cnt;
    push("lo_max", 32'hFFFF_FFFF); chk(rd);
    cyc(0, 1, MB + OFF_CYC_HI, 0);
    push("hi_snap0", 0);       chk(rd);
    cyc(0, 1, MB + OFF_CYC_LO, 0);
    push("lo_wrap", 1);        chk(rd);
    cyc(0, 1, MB + OFF_CYC_HI, 0);
    push("hi_snap1", 1);       chk(rd);

    cyc(1, 0, MB + OFF_LED, 32'h3C);
    cyc(0, 1, MB + OFF_CYC_LO, 0);
    v = rd;
    cyc(1, 0, MB + OFF_TCMP, v + 32'd3);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      if (timer_irq) break;
    end
    push("irq_b4rst", 1);      chk({31'd0, timer_irq});
    push("leds_b4rst", 32'h3C); chk({24'd0, leds});

    @(negedge clk);
    reset = 1'b1;
    we = 1; re = 0; a = MB + OFF_LED; wd = 32'hFF;
    #1;
    cyc(1, 0, 32'h10, 0);
    push("rst_leds2", 0);      chk({24'd0, leds});
    push("rst_irq2", 0);       chk({31'd0, timer_irq});
    @(negedge clk);
    reset = 1'b0;
    we = 0; re = 1; a = MB + OFF_CYC_LO;
    #1;
    push("cnt_restart", 0);    chk(rd);
    cyc(0, 1, MB + OFF_CYC_LO, 0);
    push("cnt_restart1", 1);   chk(rd);
    cyc(0, 1, 32'h10, 0);
    push("ram_retain", 32'hDEAD_BEEF); chk(rd);

    if (!hit) $display("note: counter never read 20");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit RAM words (power of two, 16..4096).
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_FF00, base of the 256-byte peripheral window.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  store strobe from core (MemWrite).
REQ-006 re  input  1  load strobe from core (MemRead).
REQ-007 a  input  32  byte address (core ALUResult).
REQ-008 wd  input  32  store data (core WriteData).
REQ-009 rd  output  32  load data (core ReadData), combinational from a.
REQ-010 leds  output  8  LED register contents.
REQ-011 timer_irq  output  1  sticky timer-match flag.
REQ-012 addr_err  output  1  combinational: (we|re) with a[1:0]!=0 or a unmapped.

Function
REQ-013 Map: RAM at 0 .. 4*DEPTH-1, word index a[log2(DEPTH)+1:2]; MMIO at MMIO_BASE+offset; all else unmapped.
REQ-014 MMIO offsets: 0x00 LED (RW, bits 7:0), 0x04 CYCLE_LO (RO), 0x08 CYCLE_HI (RO, snapshot), 0x0C TIMER_CMP (RW, 32b), 0x10 TIMER_STAT (bit0 = flag, W1C).
REQ-015 rd is combinational, zero-latency, independent of re, so the single-cycle core completes loads in one cycle.
REQ-016 rd returns 0 for unmapped or misaligned a; unused register bits read 0.
REQ-017 RAM write: on rising edge with we=1, aligned, in RAM range -> word written; visible on rd next cycle.
REQ-018 Same-cycle read and write of one address: rd shows old contents that cycle.
REQ-019 Misaligned, unmapped, or RO-register writes are ignored; no state changes.
REQ-020 Cycle counter: 64 bits, +1 every cycle not in reset, wraps 2^64-1 -> 0.
REQ-021 CYCLE_LO read returns current low word; if re=1 that cycle, high word is latched into snapshot at the edge.
REQ-022 CYCLE_HI read returns the snapshot, never the live high word.
REQ-023 Timer match: when TIMER_CMP!=0 and counter low word equals TIMER_CMP, flag sets next edge; flag stays set until cleared.
REQ-024 Writing wd[0]=1 to TIMER_STAT clears flag; if match and clear coincide, set wins.
REQ-025 timer_irq equals the flag register directly (registered output).
REQ-026 Writing TIMER_CMP does not alter the flag.
REQ-027 we and re both high: write performed and rd valid; snapshot rule of REQ-021 still applies.

Reset
REQ-028 During reset: counter, snapshot, LED, TIMER_CMP, flag all 0; leds=0, timer_irq=0 the cycle after reset asserted.
REQ-029 RAM contents not reset; writes presented while reset=1 are ignored.
REQ-030 Counter reads 0 in first cycle after reset deasserts, 1 in the next.
REQ-031 Reset mid-operation aborts any pending snapshot/flag update; reset dominates all writes.

Structure
REQ-032 Shared package mem_map_pkg holds MMIO_BASE default, register offset constants, and RAM-base constant, also used by core testbenches.
REQ-033 One sub-module cycle_timer: 64-bit counter, snapshot, compare register, flag; RAM array and decode stay in data_mem_resp.
REQ-034 RAM is a plain register array inferable as distributed RAM (async read, sync write).

Verification
REQ-035 Write 0xDEADBEEF to 0x10, read 0x10 same cycle -> old value; next cycle -> 0xDEADBEEF.
REQ-036 Write 0x1A5 to MMIO_BASE+0x00 -> leds=0xA5; read returns 0x000000A5; write to 0x04 ignored.
REQ-037 Force counter to 0x0000_0000_FFFF_FFFF, read CYCLE_LO with re=1 -> 0xFFFFFFFF; CYCLE_HI next cycle -> 0x00000000 despite live high=1.
REQ-038 TIMER_CMP=20 after reset -> timer_irq rises after edge where low word=20; W1C clears; clear coinciding with match -> stays 1.
REQ-039 re=1 at a=0x13 or a=0x8000_0000 -> addr_err=1, rd=0; store there changes no RAM word.
REQ-040 Assert reset mid-run with leds=0x3C, flag=1 -> next cycle leds=0, timer_irq=0, counter restarts at 0; RAM word at 0x10 retained.
